benes_cfg_ctrl: RTL and testbench
=================================

BENES_CFG_CTRL -- requirements
Module: benes_cfg_ctrl

Interface
REQ-001 Parameter SIZE, default 32, network port count (from usr_fun).
REQ-002 Parameter SWITCH_NUM, default SIZE/2 = 16, switches per stage.
REQ-003 Parameter STAGE_NUM, default 2*log2(SIZE)-1 = 9, registered Benes stages.
REQ-004 Port clk  input  1  single clock for all state; rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port cfg_we  input  1  write strobe into shadow config bank.
REQ-007 Port cfg_addr  input  4  stage index of the write.
REQ-008 Port cfg_wdata  input  SWITCH_NUM  switch_set word for that stage.
REQ-009 Port cfg_commit  input  1  request to make shadow bank active.
REQ-010 Port cfg_busy  output  1  high while a commit is pending (DRAIN or SWAP state).
REQ-011 Port cfg_err  output  1  sticky flag for dropped or out-of-range writes.
REQ-012 Port bank_sel  output  1  index of the active bank.
REQ-013 Port in_valid  input  1  upstream offers a vector to stage 0 this cycle.
REQ-014 Port in_ready  output  1  controller accepts the vector this cycle.
REQ-015 Port out_valid  output  1  last stage output holds a valid vector.
REQ-016 Port switch_set  output  array [0:STAGE_NUM-1] of SWITCH_NUM  per-stage switch settings.

Function
REQ-017 Two banks of STAGE_NUM x SWITCH_NUM registers SHALL exist; active = bank[bank_sel], shadow = the other.
REQ-018 switch_set[k] SHALL equal active bank word k, combinationally from registers, with no added cycle.
REQ-019 Write acceptance: cfg_we=1, cfg_busy=0 and cfg_addr<STAGE_NUM SHALL write cfg_wdata to shadow word cfg_addr at the clock edge.
REQ-020 Dropped writes: cfg_we=1 with cfg_addr>=STAGE_NUM or cfg_busy=1 SHALL be dropped and set cfg_err, which stays 1 until reset.
REQ-021 FSM states SHALL be RUN, DRAIN and SWAP; in_ready=1 only in RUN (Moore); cfg_busy=1 in DRAIN and SWAP.
REQ-022 RUN SHALL go to DRAIN when cfg_commit=1; otherwise it stays in RUN.
REQ-023 DRAIN SHALL go to SWAP in a cycle where all valid-tracker bits are 0; otherwise it stays in DRAIN.
REQ-024 SWAP SHALL toggle bank_sel at its closing edge and return to RUN.
REQ-025 cfg_commit in DRAIN or SWAP SHALL be ignored.
REQ-026 Valid tracker: STAGE_NUM-bit shift register vld; vld[0] <= in_valid & in_ready; vld[k] <= vld[k-1]; out_valid = vld[STAGE_NUM-1].
REQ-027 Latency: a vector accepted in cycle t SHALL have out_valid=1 in cycle t+STAGE_NUM; output has no backpressure.
REQ-028 Every accepted vector SHALL traverse all stages under one configuration; the bank never changes while any vld bit is 1.
REQ-029 Same-cycle events in RUN: with in_valid, cfg_we and cfg_commit together, the vector is accepted and the write is performed before DRAIN.
REQ-030 After a swap the new shadow bank SHALL hold the previous active contents; no copy is made.
REQ-031 Commit with an empty pipe SHALL give DRAIN for 1 cycle, then SWAP, then RUN, with the new config visible 3 cycles after the commit cycle.

Reset
REQ-032 rst_n=0 SHALL asynchronously clear both banks to 0 (straight-through), bank_sel=0, vld=0 and cfg_err=0, and force state RUN.
REQ-033 During reset in_ready SHALL be 0; after deassertion in_ready=1, cfg_busy=0 and out_valid=0.
REQ-034 Reset mid-DRAIN SHALL abandon the commit; bank_sel stays 0 and in-flight valids are discarded.

Verification
REQ-035 After reset, in_valid=1 in cycle 0 -> out_valid=1 in cycle 9; all switch_set=0.
REQ-036 Write 0xFFFF to shadow stages 0..8, commit on an empty pipe in cycle t -> cfg_busy in t+1..t+2, bank_sel=1 and switch_set[k]=0xFFFF from t+3.
REQ-037 Continuous in_valid with commit in cycle t -> in_ready=0 from t+1; last out_valid at t+9; SWAP in t+11; RUN with the new bank in t+12; no out_valid gap error.
REQ-038 cfg_we with cfg_addr=9, and cfg_we during DRAIN -> shadow unchanged, cfg_err=1 and held until reset.
REQ-039 rst_n pulsed low during DRAIN with 4 vectors in flight -> out_valid=0 immediately, bank_sel=0, state RUN.

Source files
------------

// File: rtl/benes_cfg_ctrl.sv
// Benes network configuration controller: double-buffered per-stage switch
// settings with a commit handshake that swaps banks only once the pipeline
// has drained, so every vector sees a single configuration end to end.
module benes_cfg_ctrl #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned SWITCH_NUM = SIZE / 2,
  parameter int unsigned STAGE_NUM  = 2 * $clog2(SIZE) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [SWITCH_NUM-1:0] cfg_wdata,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  output logic                  bank_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1]
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  err_q, err_d;
  logic [STAGE_NUM-1:0]  vld_q, vld_d;
  logic [SWITCH_NUM-1:0] bank_q [0:1][0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] bank_d [0:1][0:STAGE_NUM-1];
  logic                  addr_ok;
  logic                  wr_en;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: commit only honoured in RUN, swap once the pipe is empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_commit) state_d = DRAIN;
      DRAIN:   if (vld_q == '0) state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready = (state_q == RUN) && rst_n;
    cfg_busy = (state_q != RUN);
  end

  // Datapath next-state: shadow writes, error flag, bank toggle, valid tracker
  always_comb begin
    bank_d     = bank_q;
    addr_ok    = (32'(cfg_addr) < STAGE_NUM);
    wr_en      = cfg_we && !cfg_busy && addr_ok;
    err_d      = err_q | (cfg_we & ~wr_en);
    bank_sel_d = bank_sel_q ^ (state_q == SWAP);
    vld_d      = {vld_q[STAGE_NUM-2:0], in_valid & in_ready};
    if (wr_en) begin
      bank_d[~bank_sel_q][cfg_addr] = cfg_wdata;
    end
  end

  // Datapath registers; reset restores straight-through in both banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= '{default: '0};
      bank_sel_q <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= '0;
    end else begin
      bank_q     <= bank_d;
      bank_sel_q <= bank_sel_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
    end
  end

  // Active bank drives the switch settings directly from the registers
  always_comb begin
    for (int unsigned k = 0; k < STAGE_NUM; k++) begin
      switch_set[k] = bank_q[bank_sel_q][k];
    end
    bank_sel  = bank_sel_q;
    cfg_err   = err_q;
    out_valid = vld_q[STAGE_NUM-1];
  end

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// Directed self-checking bench for benes_cfg_ctrl (default parameters).
module tb_benes_cfg_ctrl;

  localparam int SW = 16;
  localparam int ST = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [SW-1:0] cfg_wdata;
  logic          cfg_commit;
  logic          cfg_busy;
  logic          cfg_err;
  logic          bank_sel;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] switch_set [0:ST-1];

  int tests = 0;
  int fails = 0;

  benes_cfg_ctrl #(.SIZE(32), .SWITCH_NUM(SW), .STAGE_NUM(ST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .bank_sel   (bank_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .switch_set (switch_set)
  );

  always #5 clk = ~clk;

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_commit = 1'b0; in_valid = 1'b0;
    tick(); tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (bank_sel !== 1'b0) begin fails++; $display("FAIL reset_bank_sel: got %b want 0", bank_sel); end
    tests++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    for (int k = 0; k < ST; k++) begin
      tests++; if (switch_set[k] !== 16'h0000) begin fails++; $display("FAIL reset_switch_set[%0d]: got %h want 0000", k, switch_set[k]); end
    end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    tick();
    in_valid = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      tests++;
      if (out_valid !== (c == 9)) begin
        fails++; $display("FAIL lat_out_valid cycle %0d: got %b want %b", c, out_valid, (c == 9));
      end
    end
    for (int k = 0; k < ST; k++) begin
      tests++; if (switch_set[k] !== 16'h0000) begin fails++; $display("FAIL lat_switch_set[%0d]: got %h want 0000", k, switch_set[k]); end
    end
  endtask

  task automatic test_swap();
    for (int i = 0; i < ST; i++) begin
      tick();
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = 16'hFFFF;
    end
    tick();
    cfg_we = 1'b0;
    for (int k = 0; k < ST; k++) begin
      tests++; if (switch_set[k] !== 16'h0000) begin fails++; $display("FAIL swap_pre_switch_set[%0d]: got %h want 0000", k, switch_set[k]); end
    end
    cfg_commit = 1'b1;
    tests++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL swap_t_busy: got %b want 0", cfg_busy); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      cfg_commit = 1'b0;
      tests++; if (cfg_busy !== (k < 3)) begin fails++; $display("FAIL swap_busy t+%0d: got %b want %b", k, cfg_busy, (k < 3)); end
      tests++; if (in_ready !== (k == 3)) begin fails++; $display("FAIL swap_in_ready t+%0d: got %b want %b", k, in_ready, (k == 3)); end
      tests++; if (bank_sel !== (k == 3)) begin fails++; $display("FAIL swap_bank_sel t+%0d: got %b want %b", k, bank_sel, (k == 3)); end
    end
    for (int k = 0; k < ST; k++) begin
      tests++; if (switch_set[k] !== 16'hFFFF) begin fails++; $display("FAIL swap_switch_set[%0d]: got %h want ffff", k, switch_set[k]); end
    end
  endtask

  // old active bank becomes the shadow untouched: one write then swap back
  task automatic test_reswap();
    logic [SW-1:0] exp;
    tick();
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 16'h1234; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    tick(); tick();
    tests++; if (bank_sel !== 1'b0) begin fails++; $display("FAIL reswap_bank_sel: got %b want 0", bank_sel); end
    for (int k = 0; k < ST; k++) begin
      exp = (k == 3) ? 16'h1234 : 16'h0000;
      tests++; if (switch_set[k] !== exp) begin fails++; $display("FAIL reswap_switch_set[%0d]: got %h want %h", k, switch_set[k], exp); end
    end
  endtask

  task automatic test_drain();
    tick();
    in_valid = 1'b1;
    repeat (10) tick();
    cfg_commit = 1'b1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_t_out_valid: got %b want 1", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL drain_t_in_ready: got %b want 1", in_ready); end
    for (int k = 1; k <= 13; k++) begin
      tick();
      cfg_commit = 1'b0;
      tests++; if (in_ready !== (k >= 12)) begin fails++; $display("FAIL drain_in_ready t+%0d: got %b want %b", k, in_ready, (k >= 12)); end
      tests++; if (cfg_busy !== (k <= 11)) begin fails++; $display("FAIL drain_busy t+%0d: got %b want %b", k, cfg_busy, (k <= 11)); end
      tests++; if (out_valid !== (k <= 9)) begin fails++; $display("FAIL drain_out_valid t+%0d: got %b want %b", k, out_valid, (k <= 9)); end
      tests++; if (bank_sel !== (k >= 12)) begin fails++; $display("FAIL drain_bank_sel t+%0d: got %b want %b", k, bank_sel, (k >= 12)); end
      tests++; if (switch_set[5] !== ((k >= 12) ? 16'hFFFF : 16'h0000)) begin
        fails++; $display("FAIL drain_switch_set5 t+%0d: got %h", k, switch_set[5]);
      end
    end
    in_valid = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_err();
    logic [SW-1:0] exp;
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL err_initial: got %b want 0", cfg_err); end
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 16'hAAAA;
    tick();
    cfg_we = 1'b0;
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL err_addr9: got %b want 1", cfg_err); end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tests++; if (cfg_busy !== 1'b1) begin fails++; $display("FAIL err_busy: got %b want 1", cfg_busy); end
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h5555;
    tick();
    cfg_we = 1'b0;
    tick();
    repeat (5) tick();
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", cfg_err); end
    tests++; if (bank_sel !== 1'b0) begin fails++; $display("FAIL err_bank_sel: got %b want 0", bank_sel); end
    for (int k = 0; k < ST; k++) begin
      exp = (k == 3) ? 16'h1234 : 16'h0000;
      tests++; if (switch_set[k] !== exp) begin fails++; $display("FAIL err_switch_set[%0d]: got %h want %h", k, switch_set[k], exp); end
    end
  endtask

  task automatic test_reset_drain();
    tick();
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (5) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstd_pre_out_valid: got %b want 1", out_valid); end
    tests++; if (cfg_busy !== 1'b1) begin fails++; $display("FAIL rstd_pre_busy: got %b want 1", cfg_busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstd_out_valid: got %b want 0", out_valid); end
    tests++; if (bank_sel !== 1'b0) begin fails++; $display("FAIL rstd_bank_sel: got %b want 0", bank_sel); end
    tests++; if (cfg_busy !== 1'b0) begin fails++; $display("FAIL rstd_busy: got %b want 0", cfg_busy); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL rstd_err: got %b want 0", cfg_err); end
    tests++; if (switch_set[3] !== 16'h0000) begin fails++; $display("FAIL rstd_switch_set3: got %h want 0000", switch_set[3]); end
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstd_flush cycle %0d: got %b want 0", c, out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstd_in_ready cycle %0d: got %b want 1", c, in_ready); end
    end
    tests++; if (bank_sel !== 1'b0) begin fails++; $display("FAIL rstd_final_bank_sel: got %b want 0", bank_sel); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_swap();
    test_reswap();
    test_drain();
    test_err();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
